// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//
// Match sequencer for a two-player paddle game. It is a Moore FSM
// (IDLE -> SERVE -> PLAY -> POINT -> SERVE ... -> OVER) that keeps the scores
// and selects the serve direction. It also gates the paddle and ball engines.
//
// Parameters
//   WIN_SCORE   : score that ends a match (1..15)
//   SERVE_TICKS : frame ticks waited in SERVE before the ball is released
//   POINT_TICKS : frame ticks paused in POINT after a miss
//
// Ports
//   clk        in   system clock; every state change happens on its rising edge
//   rst        in   asynchronous active-high reset
//   tick       in   one-clk pulse, once per video frame
//   start      in   start button, active low (0 = pressed)
//   miss_l     in   ball passed the left edge (point to player 2)
//   miss_r     in   ball passed the right edge (point to player 1)
//   paddle_en  out  paddle movement enable
//   ball_en    out  ball motion enable
//   ball_rst   out  hold ball at centre
//   serve_dir  out  0 = serve toward player 2 (right), 1 = toward player 1 (left)
//   score1/2   out  player scores
//   winner     out  00 none, 01 player 1, 10 player 2
//   state      out  current state code
// -----------------------------------------------------------------------------
module game_sequencer #(
  parameter int unsigned WIN_SCORE   = 5,
  parameter int unsigned SERVE_TICKS = 60,
  parameter int unsigned POINT_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       paddle_en,
  output logic       ball_en,
  output logic       ball_rst,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [3:0] WIN_C   = 4'(WIN_SCORE);
  localparam logic [6:0] SERVE_C = 7'(SERVE_TICKS);
  localparam logic [6:0] POINT_C = 7'(POINT_TICKS);

  state_t     state_r, state_nxt_s;
  logic [6:0] cnt_r, cnt_nxt_s;
  logic [3:0] score1_r, score1_nxt_s;
  logic [3:0] score2_r, score2_nxt_s;
  logic [1:0] winner_r, winner_nxt_s;
  logic       dir_r, dir_nxt_s;
  logic       start_r;
  logic       armed_r;
  logic       press_s;

  // A button already held down when reset is released must not count as a
  // press. The first clk after reset only samples start; it does not start play.
  assign press_s = armed_r & start_r & ~start;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      cnt_r    <= 7'd0;
      score1_r <= 4'd0;
      score2_r <= 4'd0;
      winner_r <= 2'b00;
      dir_r    <= 1'b0;
      start_r  <= 1'b1;
      armed_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      score1_r <= score1_nxt_s;
      score2_r <= score2_nxt_s;
      winner_r <= winner_nxt_s;
      dir_r    <= dir_nxt_s;
      start_r  <= start;
      armed_r  <= 1'b1;
    end
  end

  // Next-state, counter and score logic.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    score1_nxt_s = score1_r;
    score2_nxt_s = score2_r;
    winner_nxt_s = winner_r;
    dir_nxt_s    = dir_r;
    case (state_r)
      S_IDLE, S_OVER: begin
        if (press_s) begin
          state_nxt_s  = S_SERVE;
          cnt_nxt_s    = SERVE_C;
          score1_nxt_s = 4'd0;
          score2_nxt_s = 4'd0;
          winner_nxt_s = 2'b00;
          dir_nxt_s    = 1'b0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_SERVE: begin
        if (cnt_r == 7'd0) begin
          state_nxt_s = S_PLAY;
        end else if (tick) begin
          cnt_nxt_s = cnt_r - 7'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      S_PLAY: begin
        // Simultaneous misses on both edges cancel each other out.
        if (miss_l && !miss_r) begin
          score2_nxt_s = (score2_r < WIN_C) ? score2_r + 4'd1 : score2_r;
          dir_nxt_s    = 1'b1;
          state_nxt_s  = S_POINT;
          cnt_nxt_s    = POINT_C;
        end else if (miss_r && !miss_l) begin
          score1_nxt_s = (score1_r < WIN_C) ? score1_r + 4'd1 : score1_r;
          dir_nxt_s    = 1'b0;
          state_nxt_s  = S_POINT;
          cnt_nxt_s    = POINT_C;
        end else begin
          state_nxt_s = S_PLAY;
        end
      end
      S_POINT: begin
        if (cnt_r == 7'd0) begin
          if (score1_r == WIN_C) begin
            winner_nxt_s = 2'b01;
            state_nxt_s  = S_OVER;
          end else if (score2_r == WIN_C) begin
            winner_nxt_s = 2'b10;
            state_nxt_s  = S_OVER;
          end else begin
            state_nxt_s = S_SERVE;
            cnt_nxt_s   = SERVE_C;
          end
        end else if (tick) begin
          cnt_nxt_s = cnt_r - 7'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Moore output decode. It uses only the state register.
  always_comb begin
    paddle_en = 1'b0;
    ball_en   = 1'b0;
    ball_rst  = 1'b1;
    case (state_r)
      S_SERVE: begin
        paddle_en = 1'b1;
      end
      S_PLAY: begin
        paddle_en = 1'b1;
        ball_en   = 1'b1;
        ball_rst  = 1'b0;
      end
      default: begin
        paddle_en = 1'b0;
        ball_en   = 1'b0;
        ball_rst  = 1'b1;
      end
    endcase
  end

  assign state     = state_r;
  assign score1    = score1_r;
  assign score2    = score2_r;
  assign winner    = winner_r;
  assign serve_dir = dir_r;

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
//
// Directed self-checking bench for game_sequencer with WIN_SCORE=2,
// SERVE_TICKS=2 and POINT_TICKS=1. Inputs are driven and outputs are sampled
// 1 time unit after each rising clk edge.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       start;
  logic       miss_l;
  logic       miss_r;
  logic       paddle_en;
  logic       ball_en;
  logic       ball_rst;
  logic       serve_dir;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] winner;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  game_sequencer #(
    .WIN_SCORE  (2),
    .SERVE_TICKS(2),
    .POINT_TICKS(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .start    (start),
    .miss_l   (miss_l),
    .miss_r   (miss_r),
    .paddle_en(paddle_en),
    .ball_en  (ball_en),
    .ball_rst (ball_rst),
    .serve_dir(serve_dir),
    .score1   (score1),
    .score2   (score2),
    .winner   (winner),
    .state    (state)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic press();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  // Check the outputs that are fixed while the FSM is in a rest state.
  task automatic check_rest(input string tag, input logic [2:0] st,
                            input logic [3:0] s1, input logic [3:0] s2,
                            input logic [1:0] w);
    check({tag, "_state"}, state, st);
    check({tag, "_score1"}, score1, s1);
    check({tag, "_score2"}, score2, s2);
    check({tag, "_winner"}, winner, w);
    check({tag, "_paddle"}, paddle_en, 1'b0);
    check({tag, "_ball_en"}, ball_en, 1'b0);
    check({tag, "_ball_rst"}, ball_rst, 1'b1);
  endtask

  // SERVE with a counter of 2: two ticks, then PLAY on the following clk.
  task automatic serve_to_play(input string tag);
    tick_pulse();
    check({tag, "_serve1"}, state, 3'd1);
    tick_pulse();
    check({tag, "_serve0"}, state, 3'd1);
    step();
    check({tag, "_play"}, state, 3'd2);
  endtask

  initial begin
    rst    = 1'b1;
    tick   = 1'b0;
    start  = 1'b0;
    miss_l = 1'b0;
    miss_r = 1'b0;
    step();
    step();
    check_rest("reset", 3'd0, 4'd0, 4'd0, 2'b00);
    check("reset_dir", serve_dir, 1'b0);

    // Start is held low through reset release, so no press is detected.
    rst = 1'b0;
    step();
    step();
    step();
    check("held_start_idle", state, 3'd0);

    // A real press moves to SERVE on the next clk.
    press();
    check("press_serve", state, 3'd1);
    check("serve_paddle", paddle_en, 1'b1);
    check("serve_ball_en", ball_en, 1'b0);
    check("serve_ball_rst", ball_rst, 1'b1);
    step();
    check("serve_no_tick", state, 3'd1);

    tick_pulse();
    check("serve_cnt1", state, 3'd1);
    tick_pulse();
    check("serve_cnt0", state, 3'd1);
    step();
    check("play_state", state, 3'd2);
    check("play_ball_en", ball_en, 1'b1);
    check("play_ball_rst", ball_rst, 1'b0);
    check("play_paddle", paddle_en, 1'b1);

    // A press during PLAY is ignored.
    press();
    check("press_in_play", state, 3'd2);

    // Misses on both edges in the same clk are ignored.
    miss_l = 1'b1;
    miss_r = 1'b1;
    step();
    miss_l = 1'b0;
    miss_r = 1'b0;
    check("both_state", state, 3'd2);
    check("both_score1", score1, 4'd0);
    check("both_score2", score2, 4'd0);

    // A miss on the right edge scores for player 1.
    miss_r = 1'b1;
    step();
    miss_r = 1'b0;
    check_rest("miss_r", 3'd3, 4'd1, 4'd0, 2'b00);
    check("miss_r_dir", serve_dir, 1'b0);

    // A miss outside PLAY is ignored.
    miss_r = 1'b1;
    step();
    miss_r = 1'b0;
    check("miss_in_point_score1", score1, 4'd1);
    check("miss_in_point_state", state, 3'd3);

    tick_pulse();
    check("point_cnt0", state, 3'd3);
    step();
    check("point_to_serve", state, 3'd1);
    serve_to_play("rally2");

    // An asynchronous reset mid-match restores the reset values without a clk edge.
    #2;
    rst = 1'b1;
    #1;
    check_rest("async_rst", 3'd0, 4'd0, 4'd0, 2'b00);
    check("async_rst_dir", serve_dir, 1'b0);
    step();
    rst = 1'b0;
    step();
    step();
    check("after_rst_idle", state, 3'd0);

    press();
    check("restart_serve", state, 3'd1);
    serve_to_play("m1");

    // Two misses on the left edge give player 2 the match.
    miss_l = 1'b1;
    step();
    miss_l = 1'b0;
    check_rest("miss_l1", 3'd3, 4'd0, 4'd1, 2'b00);
    check("miss_l1_dir", serve_dir, 1'b1);
    tick_pulse();
    step();
    check("miss_l1_serve", state, 3'd1);
    serve_to_play("m2");

    miss_l = 1'b1;
    step();
    miss_l = 1'b0;
    check_rest("miss_l2", 3'd3, 4'd0, 4'd2, 2'b00);
    tick_pulse();
    step();
    check_rest("over", 3'd4, 4'd0, 4'd2, 2'b10);

    miss_l = 1'b1;
    step();
    miss_l = 1'b0;
    check_rest("over_miss", 3'd4, 4'd0, 4'd2, 2'b10);

    // A press in OVER clears the match and serves again.
    press();
    check("over_press_state", state, 3'd1);
    check("over_press_score2", score2, 4'd0);
    check("over_press_winner", winner, 2'b00);
    check("over_press_dir", serve_dir, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 5, score that ends a match (range 1..15).
REQ-002 SHALL have parameter SERVE_TICKS, default 60, frame ticks waited in SERVE before the ball is released.
REQ-003 SHALL have parameter POINT_TICKS, default 30, frame ticks paused in POINT after a miss.
REQ-004 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port tick, input, 1, one-clk frame pulse (once per video frame).
REQ-007 SHALL have port start, input, 1, active-low start button (0 = pressed).
REQ-008 SHALL have port miss_l, input, 1, ball passed the left edge this clk; point to player 2.
REQ-009 SHALL have port miss_r, input, 1, ball passed the right edge this clk; point to player 1.
REQ-010 SHALL have port paddle_en, output, 1, paddle movement enable.
REQ-011 SHALL have port ball_en, output, 1, ball motion enable.
REQ-012 SHALL have port ball_rst, output, 1, ball held at centre while 1.
REQ-013 SHALL have port serve_dir, output, 1, serve direction (0 = toward player 2/right, 1 = toward player 1/left).
REQ-014 SHALL have ports score1 and score2, output, 4 each, player scores.
REQ-015 SHALL have port winner, output, 2, 00 none, 01 player 1, 10 player 2.
REQ-016 SHALL have port state, output, 3, current state encoding.

Function
REQ-017 SHALL implement a Moore FSM: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; codes 5..7 SHALL go to IDLE on the next clk.
REQ-018 SHALL register start every clk and define a press as registered start=1 with current start=0 (falling edge); a held button SHALL yield exactly one press.
REQ-019 In IDLE: paddle_en=0, ball_en=0, ball_rst=1; on a press, SHALL clear scores, set serve_dir=0, clear winner, and enter SERVE.
REQ-020 On entry to SERVE or POINT, SHALL load a 7-bit down-counter with SERVE_TICKS or POINT_TICKS respectively.
REQ-021 In SERVE: paddle_en=1, ball_en=0, ball_rst=1; the counter SHALL decrement on each tick while nonzero; when the counter is 0, SHALL enter PLAY on the next clk.
REQ-022 With a tick parameter of 0, SHALL remain in SERVE or POINT for exactly one clk.
REQ-023 In PLAY: paddle_en=1, ball_en=1, ball_rst=0.
REQ-024 In PLAY, miss_l alone SHALL increment score2, set serve_dir=1, and enter POINT.
REQ-025 In PLAY, miss_r alone SHALL increment score1, set serve_dir=0, and enter POINT.
REQ-026 In PLAY, miss_l and miss_r in the same clk SHALL be ignored: no score change and no state change.
REQ-027 miss_l and miss_r outside PLAY SHALL be ignored.
REQ-028 Score increments SHALL saturate at WIN_SCORE and never wrap.
REQ-029 In POINT: paddle_en=0, ball_en=0, ball_rst=1; the counter SHALL decrement on tick.
REQ-030 When the POINT counter is 0: if score1==WIN_SCORE, SHALL set winner=01 and enter OVER; else if score2==WIN_SCORE, SHALL set winner=10 and enter OVER; else SHALL enter SERVE.
REQ-031 In OVER: paddle_en=0, ball_en=0, ball_rst=1, scores and winner held; a press SHALL behave as in IDLE (clear, then SERVE).
REQ-032 A press in SERVE, PLAY or POINT SHALL be ignored.
REQ-033 Outputs SHALL be decoded from registered state and registers only; no combinational input-to-output path.

Reset
REQ-034 While rst=1, SHALL hold: state=IDLE, score1=score2=0, winner=00, serve_dir=0, counter=0, registered start=1, paddle_en=0, ball_en=0, ball_rst=1.
REQ-035 rst asserted mid-match SHALL abort immediately to the reset values; after release, only a new press starts play.

Verification (SERVE_TICKS=2, POINT_TICKS=1, WIN_SCORE=2)
REQ-036 Reset release, start held low from before release -> no press; state stays 0 until start goes 1 then 0, then state=1 the next clk.
REQ-037 In SERVE, 2 tick pulses -> state=2 one clk after the counter reaches 0; ball_en=1, ball_rst=0.
REQ-038 In PLAY, miss_r pulse -> score1=1, serve_dir=0, state=3; after 1 tick, state=1.
REQ-039 In PLAY, miss_l and miss_r in the same clk -> scores unchanged, state stays 2.
REQ-040 Two miss_l points -> score2=2, then after POINT: winner=10, state=4; a further miss_l has no effect; a press -> scores 0, winner 00, state=1.
REQ-041 rst pulse while in PLAY with score1=1 -> all REQ-034 values on the same edge, asynchronously.
